// File: rtl/sram_responder_if.sv
// CPU-side SRAM bus between the LC-3 datapath and the memory responder.
// Chip controls are active-low, as they are on the board SRAM part.
interface sram_responder_if;
  logic [15:0] ADDR;
  logic        CE;
  logic        UB;
  logic        LB;
  logic        OE;
  logic        WE;
  logic [15:0] Data_from_CPU;
  logic [15:0] Data_to_CPU;
  logic        Data_drive;
  logic        Ready;

  modport master (
    output ADDR, CE, UB, LB, OE, WE, Data_from_CPU,
    input  Data_to_CPU, Data_drive, Ready
  );

  modport slave (
    input  ADDR, CE, UB, LB, OE, WE, Data_from_CPU,
    output Data_to_CPU, Data_drive, Ready
  );
endinterface

// File: rtl/sram_responder.sv
// Memory-side responder: captures a CPU SRAM request, waits WAIT_STATES cycles,
// then reads/writes the on-chip word array or the switch/hex I/O port.
module sram_responder #(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_STATES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic                Clk,
  input  logic                Reset,
  sram_responder_if.slave     bus,
  input  logic [15:0]         Switches,
  output logic [15:0]         Hex_out
);

  localparam int        DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, BUSY, ACCESS, HOLD} state_t;

  state_t                 state_reg, state_next;
  logic [3:0]             count_reg, count_next;
  logic [ADDR_WIDTH-1:0]  addr_reg;
  logic [1:0]             lane_en_reg;
  logic [15:0]            wdata_reg;
  logic                   write_reg;
  logic                   io_reg;
  logic [15:0]            data_reg;
  logic [15:0]            hex_reg;
  logic [15:0]            src_word;
  logic [15:0]            rd_masked;
  logic                   req_valid;

  logic [15:0] mem [0:DEPTH-1];

  assign req_valid = !bus.CE && (!bus.OE || !bus.WE);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg <= IDLE;
      count_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          count_next = WAIT_LOAD;
          state_next = (WAIT_STATES > 0) ? BUSY : ACCESS;
        end
      end
      BUSY: begin
        if (bus.CE) begin
          state_next = IDLE;
        end else begin
          count_next = count_reg - 4'd1;
          if (count_reg <= 4'd1) state_next = ACCESS;
        end
      end
      ACCESS: state_next = HOLD;
      HOLD: begin
        if (bus.CE || (bus.OE && bus.WE)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture; write wins when OE and WE are both low.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      addr_reg    <= '0;
      lane_en_reg <= 2'b00;
      wdata_reg   <= 16'h0000;
      write_reg   <= 1'b0;
      io_reg      <= 1'b0;
    end else if (state_reg == IDLE && req_valid) begin
      addr_reg    <= bus.ADDR[ADDR_WIDTH-1:0];
      lane_en_reg <= {!bus.UB, !bus.LB};
      wdata_reg   <= bus.Data_from_CPU;
      write_reg   <= !bus.WE;
      io_reg      <= (bus.ADDR == IO_ADDR);
    end
  end

  assign src_word = io_reg ? Switches : mem[addr_reg];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      assign rd_masked[gi*8 +: 8] = lane_en_reg[gi] ? src_word[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  // Array is deliberately left out of reset so stored words survive it.
  always_ff @(posedge Clk) begin
    if (state_reg == ACCESS && write_reg && !io_reg) begin
      for (int li = 0; li < 2; li++) begin
        if (lane_en_reg[li]) mem[addr_reg][li*8 +: 8] <= wdata_reg[li*8 +: 8];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      data_reg <= 16'h0000;
      hex_reg  <= 16'h0000;
    end else if (state_reg == ACCESS) begin
      if (!write_reg) begin
        data_reg <= rd_masked;
      end else if (io_reg) begin
        for (int li = 0; li < 2; li++) begin
          if (lane_en_reg[li]) hex_reg[li*8 +: 8] <= wdata_reg[li*8 +: 8];
        end
      end
    end
  end

  assign bus.Ready       = (state_reg == HOLD);
  assign bus.Data_drive  = (state_reg == HOLD) && !write_reg && !bus.CE && !bus.OE;
  assign bus.Data_to_CPU = data_reg;
  assign Hex_out         = hex_reg;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: table of bus transactions on a
// WAIT_STATES=2 instance plus hand sequences for abort, reset and WAIT_STATES=0.
module tb_sram_responder;

  logic        clk;
  logic        rst_n;
  logic [15:0] sw_a, sw_z;
  logic [15:0] hex_a, hex_z;

  sram_responder_if ba();
  sram_responder_if bz();

  sram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2), .IO_ADDR(16'hFFFF)) dut_a (
    .Clk(clk), .Reset(rst_n), .bus(ba), .Switches(sw_a), .Hex_out(hex_a)
  );

  sram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0), .IO_ADDR(16'hFFFF)) dut_z (
    .Clk(clk), .Reset(rst_n), .bus(bz), .Switches(sw_z), .Hex_out(hex_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb_q[$];

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic        ub;
    logic        lb;
    logic [15:0] data;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit z, input logic ce, input logic oe, input logic we,
                       input logic ub, input logic lb, input logic [15:0] addr,
                       input logic [15:0] data);
    if (z) begin
      bz.CE = ce; bz.OE = oe; bz.WE = we; bz.UB = ub; bz.LB = lb;
      bz.ADDR = addr; bz.Data_from_CPU = data;
    end else begin
      ba.CE = ce; ba.OE = oe; ba.WE = we; ba.UB = ub; ba.LB = lb;
      ba.ADDR = addr; ba.Data_from_CPU = data;
    end
  endtask

  function automatic logic rdy(input bit z);
    return z ? bz.Ready : ba.Ready;
  endfunction

  function automatic logic drv(input bit z);
    return z ? bz.Data_drive : ba.Data_drive;
  endfunction

  function automatic logic [15:0] dout(input bit z);
    return z ? bz.Data_to_CPU : ba.Data_to_CPU;
  endfunction

  task automatic idle_bus();
    drive(0, 1, 1, 1, 1, 1, 16'h0000, 16'h0000);
    drive(1, 1, 1, 1, 1, 1, 16'h0000, 16'h0000);
  endtask

  // One full request: drive, wait for Ready, compare, release CE.
  task automatic xact(input bit z, input bit wr, input bit rd, input logic [15:0] addr,
                      input logic ub, input logic lb, input logic [15:0] wdata,
                      input logic [15:0] exp, input string name);
    int k;
    bit got;
    int ws;
    logic [15:0] exp_d;
    ws = z ? 0 : 2;
    @(negedge clk);
    drive(z, 1'b0, !rd, !wr, ub, lb, addr, wdata);
    if (!wr) sb_q.push_back(exp);
    k = 0;
    got = 0;
    while (!got && k < 20) begin
      @(posedge clk);
      #1;
      k++;
      if (rdy(z)) got = 1;
    end
    check({name, " latency"}, k, ws + 2);
    if (!wr) begin
      exp_d = sb_q.pop_front();
      check({name, " data"}, dout(z), exp_d);
      check({name, " drive"}, drv(z), 1'b1);
    end else begin
      check({name, " drive"}, drv(z), 1'b0);
    end
    @(negedge clk);
    drive(z, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, addr, wdata);
    #1;
    check({name, " drive off"}, drv(z), 1'b0);
    @(posedge clk);
    #1;
    check({name, " ready clear"}, rdy(z), 1'b0);
    if (!wr) check({name, " data hold"}, dout(z), exp);
    $display("xact %-14s dut=%s %s addr=%h ub=%b lb=%b wdata=%h rdata=%h edges=%0d",
             name, z ? "ws0" : "ws2", wr ? "W" : "R", addr, ub, lb, wdata, dout(z), k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;

    vecs.push_back('{1, 16'h0005, 0, 0, 16'h1234, 16'h0000, "wr_0005"});
    vecs.push_back('{0, 16'h0005, 0, 0, 16'h0000, 16'h1234, "rd_0005"});
    vecs.push_back('{1, 16'h0010, 0, 0, 16'hAABB, 16'h0000, "wr_0010"});
    vecs.push_back('{1, 16'h0010, 1, 0, 16'h11CC, 16'h0000, "wr_0010_lo"});
    vecs.push_back('{0, 16'h0010, 0, 1, 16'h0000, 16'hAA00, "rd_0010_hi"});
    vecs.push_back('{0, 16'h0010, 0, 0, 16'h0000, 16'hAACC, "rd_0010"});
    vecs.push_back('{1, 16'h03FF, 0, 0, 16'hBEEF, 16'h0000, "wr_03ff"});
    vecs.push_back('{0, 16'hFFFF, 0, 0, 16'h0000, 16'h00F7, "rd_io"});
    vecs.push_back('{1, 16'hFFFF, 0, 0, 16'h0C3A, 16'h0000, "wr_io"});
    vecs.push_back('{0, 16'h03FF, 0, 0, 16'h0000, 16'hBEEF, "rd_03ff"});
    vecs.push_back('{1, 16'h0020, 0, 0, 16'h0102, 16'h0000, "wr_0020"});
    vecs.push_back('{1, 16'h0020, 1, 1, 16'h9999, 16'h0000, "wr_0020_none"});
    vecs.push_back('{0, 16'h0020, 0, 0, 16'h0000, 16'h0102, "rd_0020"});
    vecs.push_back('{1, 16'h0002, 0, 0, 16'h7777, 16'h0000, "wr_0002"});
    vecs.push_back('{0, 16'h0402, 0, 0, 16'h0000, 16'h7777, "rd_0402_alias"});

    sw_a = 16'h00F7;
    sw_z = 16'h1234;
    rst_n = 1'b0;
    idle_bus();
    repeat (2) @(posedge clk);
    #1;
    check("rst ready_a", ba.Ready, 1'b0);
    check("rst drive_a", ba.Data_drive, 1'b0);
    check("rst data_a", ba.Data_to_CPU, 16'h0000);
    check("rst hex_a", hex_a, 16'h0000);
    check("rst ready_z", bz.Ready, 1'b0);
    check("rst data_z", bz.Data_to_CPU, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      xact(0, vecs[i].wr, !vecs[i].wr, vecs[i].addr, vecs[i].ub, vecs[i].lb,
           vecs[i].data, vecs[i].exp, vecs[i].name);
    check("hex after io write", hex_a, 16'h0C3A);

    // Abort: CE raised during BUSY discards the write.
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0402, 16'hDEAD);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0402, 16'hDEAD);
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (ba.Ready) seen++;
    end
    check("abort no ready", seen, 0);
    $display("xact abort          dut=ws2 W addr=0402 wdata=dead ready_cycles=%0d", seen);
    xact(0, 0, 1, 16'h0002, 0, 0, 16'h0000, 16'h7777, "rd_after_abort");
    xact(0, 1, 0, 16'h0402, 0, 0, 16'hDEAD, 16'h0000, "wr_0402");
    xact(0, 0, 1, 16'h0002, 0, 0, 16'h0000, 16'hDEAD, "rd_0002_alias");

    // Reset during BUSY of a write.
    xact(0, 1, 0, 16'h0030, 0, 0, 16'hA5A5, 16'h0000, "wr_0030");
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0030, 16'h5A5A);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("busy rst ready", ba.Ready, 1'b0);
    check("busy rst data", ba.Data_to_CPU, 16'h0000);
    check("busy rst hex", hex_a, 16'h0000);
    idle_bus();
    @(negedge clk);
    rst_n = 1'b1;
    $display("xact reset_busy     dut=ws2 W addr=0030 wdata=5a5a");
    xact(0, 0, 1, 16'h0030, 0, 0, 16'h0000, 16'hA5A5, "rd_0030");

    // Reset during HOLD of a read.
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0005, 16'h0000);
    seen = 0;
    while (!ba.Ready && seen < 20) begin
      @(posedge clk);
      #1;
      seen++;
    end
    check("hold latency", seen, 4);
    check("hold data", ba.Data_to_CPU, 16'h1234);
    check("hold drive", ba.Data_drive, 1'b1);
    rst_n = 1'b0;
    #1;
    check("hold rst ready", ba.Ready, 1'b0);
    check("hold rst drive", ba.Data_drive, 1'b0);
    check("hold rst data", ba.Data_to_CPU, 16'h0000);
    idle_bus();
    @(negedge clk);
    rst_n = 1'b1;
    $display("xact reset_hold     dut=ws2 R addr=0005");
    xact(0, 0, 1, 16'h0005, 0, 0, 16'h0000, 16'h1234, "rd_0005_post");
    xact(0, 0, 1, 16'h0010, 0, 0, 16'h0000, 16'hAACC, "rd_0010_post");

    // WAIT_STATES=0: OE and WE both low is a write.
    xact(1, 1, 1, 16'h0001, 0, 0, 16'h5555, 16'h0000, "z_wr_both");
    xact(1, 0, 1, 16'h0001, 0, 0, 16'h0000, 16'h5555, "z_rd_0001");
    xact(1, 0, 1, 16'hFFFF, 1, 0, 16'h0000, 16'h0034, "z_rd_io_lo");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the LC-3 datapath's SRAM interface.
- Samples the CPU's active-low chip controls (CE/UB/LB/OE/WE) and the address from MAR, then services reads and writes against an on-chip word array after a programmable number of wait states.
- Signals completion with Ready and drives read data toward the CPU bus.
- Address xFFFF is a memory-mapped I/O port: reads return the switches, writes load the hex-display register.

Parameters:
- ADDR_WIDTH, 10, array index width; depth is 2**ADDR_WIDTH 16-bit words.
- WAIT_STATES, 2, extra cycles between request capture and access, range 0..15.
- IO_ADDR, 16'hFFFF, address decoded as the I/O port.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- ADDR  input  16  word address from MAR.
- CE  input  1  chip enable, active-low.
- UB  input  1  upper byte [15:8] enable, active-low.
- LB  input  1  lower byte [7:0] enable, active-low.
- OE  input  1  output enable (read request), active-low.
- WE  input  1  write enable, active-low.
- Data_from_CPU  input  16  write data (MDR value).
- Switches  input  16  board switch value returned on I/O reads.
- Data_to_CPU  output  16  registered read data.
- Data_drive  output  1  tri-state enable for the bus-side buffer; high only while read data is valid.
- Ready  output  1  access complete.
- Hex_out  output  16  hex-display register written via IO_ADDR.

Behaviour:
- Request valid when CE=0 and (OE=0 or WE=0).
  - WE=0 wins when OE and WE are both low: the access is a write.
- FSM states: IDLE, BUSY, ACCESS, HOLD.
- IDLE
  - On a valid request, latch ADDR, UB, LB, Data_from_CPU, op and is_io (ADDR==IO_ADDR).
  - Load the counter with WAIT_STATES.
  - Go to BUSY if WAIT_STATES>0, else ACCESS.
- BUSY
  - Decrement the counter each cycle; go to ACCESS when it reaches 1.
  - Input changes are ignored; latched values are used.
  - CE=1 sampled in BUSY aborts: return to IDLE, no write, Ready stays 0.
- ACCESS (one cycle)
  - Read: Data_to_CPU <= source word with disabled byte lanes forced to 0. Source is Switches if is_io, else array[addr[ADDR_WIDTH-1:0]].
  - Write: update only the enabled byte lanes of the array word (or Hex_out if is_io). UB=LB=1 writes nothing but still completes.
  - Ready <= 1. Go to HOLD.
- HOLD
  - Ready=1.
  - Data_drive = 1 when op=read, CE=0 and OE=0; otherwise 0 (combinational gate on registered state).
  - Leave to IDLE when CE=1 or both OE=1 and WE=1. Ready clears on that edge; Data_to_CPU holds its value.
  - A new request needs a return through IDLE. Back-to-back requests without deasserting CE are not serviced.
- Latency: a request sampled at edge t gives Ready=1 after edge t+WAIT_STATES+1.
- Addresses other than IO_ADDR alias modulo 2**ADDR_WIDTH. IO_ADDR decode uses all 16 bits, before aliasing.
- Reset=0 at any time (including mid-access):
  - State=IDLE, Ready=0, Data_drive=0, Data_to_CPU=0, Hex_out=0, counter=0.
  - Array contents are not reset.
  - A write in BUSY is discarded. A write already committed in ACCESS remains.
- No combinational path from inputs to Ready or Data_to_CPU.

Test Plan:
- Write then read, WAIT_STATES=2: write x1234 to x0005 with UB=LB=0, drop CE after Ready. Read x0005. Ready rises 3 edges after the sampling edge; Data_to_CPU=x1234 and Data_drive=1 while OE=0.
- Byte lanes: word xAABB at x0010. Write x11CC with LB=0, UB=1, then read with UB=0, LB=1. Word becomes xAACC; returned value is xAA00.
- I/O port: Switches=x00F7, read xFFFF, returns x00F7. Write x0C3A to xFFFF: Hex_out=x0C3A, and array word xFFFF&x3FF is unchanged.
- Abort and alias: start a write of xDEAD to x0402, raise CE during BUSY. Ready never asserts and x0002 is unchanged. Then write x0402 fully and read x0002, which returns xDEAD.
- Reset mid-operation: assert Reset during BUSY of a write and during HOLD of a read. Outputs go to 0 immediately (asynchronous). After release, previously stored words read back intact.
- WAIT_STATES=0 and priority: with OE=WE=0 and data x5555 at x0001, the write occurs and Ready rises after edge t+1. A subsequent read returns x5555.
